// File: rtl/dz_pkg.sv
// Shared types for the count-game display sequencer.
//   state_t : controller state
//   digit_t : 3-bit digit select, same encoding as the display driver's num
package dz_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        BLINK = 2'd3
    } state_t;

    typedef logic [2:0] digit_t;

    // Counter width for a modulo-n counter, never less than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dz_game_ctrl_if.sv
// Button/display bundle between the sequencer and its neighbours.
//   start, pause : debounced button levels (into the controller)
//   num, st      : digit select and display enable (to the dot-matrix driver)
//   busy, done   : status (RUN/PAUSE/BLINK indicator, end-of-game pulse)
interface dz_game_ctrl_if;
    import dz_pkg::*;

    logic   start;
    logic   pause;
    digit_t num;
    logic   st;
    logic   busy;
    logic   done;

    modport master (output start, pause, input num, st, busy, done);
    modport slave  (input start, pause, output num, st, busy, done);
endinterface

// File: rtl/dz_edge_rise.sv
// Registered rising-edge detector.
//   i_clk  : clock
//   i_rst  : synchronous reset, active low
//   i_in   : level input
//   o_rise : high for the cycle where i_in is 1 and its previous sample was 0
module dz_edge_rise (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_in,
    output logic o_rise
);
    logic r_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst) r_q <= 1'b0;
        else        r_q <= i_in;
    end

    assign o_rise = i_in & ~r_q;
endmodule

// File: rtl/dz_game_ctrl.sv
// Countdown sequencer for the count-game display: counts START_NUM down to 0,
// one digit per STEP_CYCLES, blinks the 0 BLINK_COUNT times, then idles.
//   i_clk : clock shared with the display driver
//   i_rst : synchronous reset, active low
//   bus   : start/pause buttons in; num/st/busy/done out (all registered)
//
// state | meaning
// IDLE  | blank display, num parked at START_NUM, waiting for start
// RUN   | digit shown, step counter advancing
// PAUSE | digit shown, step counter and digit frozen
// BLINK | digit 0 blinking, off half first then on half
module dz_game_ctrl
    import dz_pkg::*;
#(
    parameter int STEP_CYCLES  = 1000,
    parameter int BLINK_CYCLES = 250,
    parameter int BLINK_COUNT  = 3,
    parameter int START_NUM    = 7
) (
    input  logic            i_clk,
    input  logic            i_rst,
    dz_game_ctrl_if.slave   bus
);
    localparam int SW = clog2_min1(STEP_CYCLES);
    localparam int BW = clog2_min1(BLINK_CYCLES);
    localparam int HW = clog2_min1(2 * BLINK_COUNT + 1);

    localparam logic [SW-1:0] STEP_LAST  = SW'(STEP_CYCLES - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);
    localparam logic [HW-1:0] HALF_LAST  = HW'(2 * BLINK_COUNT - 1);
    localparam digit_t        START_D    = digit_t'(START_NUM);

    logic w_start_rise, w_pause_rise;

    dz_edge_rise u_start_edge (.i_clk(i_clk), .i_rst(i_rst), .i_in(bus.start), .o_rise(w_start_rise));
    dz_edge_rise u_pause_edge (.i_clk(i_clk), .i_rst(i_rst), .i_in(bus.pause), .o_rise(w_pause_rise));

    state_t        r_state, w_state_nxt;
    digit_t        r_num,   w_num_nxt;
    logic          r_st,    w_st_nxt;
    logic          r_busy,  w_busy_nxt;
    logic          r_done,  w_done_nxt;
    logic [SW-1:0] r_step_cnt,  w_step_nxt;
    logic [BW-1:0] r_blink_cnt, w_blink_nxt;
    logic [HW-1:0] r_half_cnt,  w_half_nxt;
    logic          w_adv;

    always_comb begin
        w_state_nxt = r_state;
        w_num_nxt   = r_num;
        w_st_nxt    = r_st;
        w_done_nxt  = 1'b0;
        w_step_nxt  = r_step_cnt;
        w_blink_nxt = r_blink_cnt;
        w_half_nxt  = r_half_cnt;
        w_adv       = 1'b0;

        if (w_start_rise) begin
            // Restart from any state; a simultaneous pause rise is dropped.
            w_state_nxt = RUN;
            w_num_nxt   = START_D;
            w_st_nxt    = 1'b1;
            w_step_nxt  = '0;
            w_blink_nxt = '0;
            w_half_nxt  = '0;
        end else begin
            case (r_state)
                IDLE: begin
                end
                RUN: begin
                    if (w_pause_rise) w_state_nxt = PAUSE;
                    else              w_adv       = 1'b1;
                end
                PAUSE: begin
                    // The pause edge itself did not count, so the resume edge
                    // does; otherwise each pause/resume would add one cycle.
                    if (w_pause_rise) begin
                        w_state_nxt = RUN;
                        w_adv       = 1'b1;
                    end
                end
                BLINK: begin
                    if (r_blink_cnt == BLINK_LAST) begin
                        w_blink_nxt = '0;
                        if (r_half_cnt == HALF_LAST) begin
                            w_state_nxt = IDLE;
                            w_done_nxt  = 1'b1;
                            w_st_nxt    = 1'b0;
                            w_num_nxt   = START_D;
                            w_half_nxt  = '0;
                        end else begin
                            w_st_nxt   = ~r_st;
                            w_half_nxt = r_half_cnt + HW'(1);
                        end
                    end else begin
                        w_blink_nxt = r_blink_cnt + BW'(1);
                    end
                end
                default: w_state_nxt = IDLE;
            endcase

            if (w_adv) begin
                if (r_step_cnt == STEP_LAST) begin
                    w_step_nxt = '0;
                    if (r_num != '0) begin
                        w_num_nxt = r_num - digit_t'(1);
                    end else begin
                        w_state_nxt = BLINK;
                        w_st_nxt    = 1'b0;
                        w_blink_nxt = '0;
                        w_half_nxt  = '0;
                    end
                end else begin
                    w_step_nxt = r_step_cnt + SW'(1);
                end
            end
        end

        w_busy_nxt = (w_state_nxt != IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state     <= IDLE;
            r_num       <= START_D;
            r_st        <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_step_cnt  <= '0;
            r_blink_cnt <= '0;
            r_half_cnt  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_num       <= w_num_nxt;
            r_st        <= w_st_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_step_cnt  <= w_step_nxt;
            r_blink_cnt <= w_blink_nxt;
            r_half_cnt  <= w_half_nxt;
        end
    end

    assign bus.num  = r_num;
    assign bus.st   = r_st;
    assign bus.busy = r_busy;
    assign bus.done = r_done;
endmodule

// File: tb/tb_dz_game_ctrl.sv
// Bench for dz_game_ctrl with STEP_CYCLES=4, BLINK_CYCLES=2, BLINK_COUNT=2,
// START_NUM=7. Each stimulus cycle queues the outputs expected after the
// next rising edge; a monitor pops and compares them after every edge.
module tb_dz_game_ctrl;
    import dz_pkg::*;

    typedef struct packed {
        logic       chk;
        logic [2:0] num;
        logic       st;
        logic       busy;
        logic       done;
    } exp_t;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   cyc_n    = 0;

    exp_t  q_exp[$];
    string q_name[$];

    dz_game_ctrl_if bus ();

    dz_game_ctrl #(
        .STEP_CYCLES (4),
        .BLINK_CYCLES(2),
        .BLINK_COUNT (2),
        .START_NUM   (7)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: one queued expectation per clock edge.
    always @(posedge clk) begin
        exp_t  e;
        string nm;
        #1;
        if (q_exp.size() > 0) begin
            e  = q_exp.pop_front();
            nm = q_name.pop_front();
            cyc_n++;
            if (e.chk) begin
                checks++;
                if ({bus.num, bus.st, bus.busy, bus.done} !== {e.num, e.st, e.busy, e.done}) begin
                    failures++;
                    $display("FAIL %s (cycle %0d): got num=%0d st=%0b busy=%0b done=%0b, expected num=%0d st=%0b busy=%0b done=%0b",
                             nm, cyc_n, bus.num, bus.st, bus.busy, bus.done, e.num, e.st, e.busy, e.done);
                end
            end
        end
    end

    task automatic cyc(input logic s, input logic p, input logic r, input logic chk,
                       input digit_t n, input logic st_e, input logic busy_e,
                       input logic done_e, input string nm);
        exp_t e;
        @(negedge clk);
        bus.start = s;
        bus.pause = p;
        rst       = r;
        e.chk  = chk;
        e.num  = n;
        e.st   = st_e;
        e.busy = busy_e;
        e.done = done_e;
        q_exp.push_back(e);
        q_name.push_back(nm);
    endtask

    task automatic run_hold(input logic s, input digit_t d, input int n, input string nm);
        for (int i = 0; i < n; i++) cyc(s, 1'b0, 1'b1, 1'b1, d, 1'b1, 1'b1, 1'b0, nm);
    endtask

    // Blink steps idx_from..idx_from+n-1; each off/on pair is 0,0,1,1.
    task automatic blink(input logic s, input int idx_from, input int n, input string nm);
        for (int i = idx_from; i < idx_from + n; i++)
            cyc(s, 1'b0, 1'b1, 1'b1, 3'd0, ((i % 4) >= 2), 1'b1, 1'b0, nm);
    endtask

    // Digits 6..0, four cycles each.
    task automatic count_down(input logic s, input string nm);
        for (int d = 6; d >= 0; d--) run_hold(s, digit_t'(d), 4, nm);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.pause = 1'b0;
        rst       = 1'b0;

        // Reset, with a start pulse that must be ignored.
        cyc(0, 0, 0, 1, 3'd7, 0, 0, 0, "reset");
        cyc(1, 0, 0, 1, 3'd7, 0, 0, 0, "reset_start");
        cyc(0, 0, 0, 1, 3'd7, 0, 0, 0, "reset");
        cyc(0, 0, 1, 1, 3'd7, 0, 0, 0, "idle");
        cyc(0, 1, 1, 1, 3'd7, 0, 0, 0, "idle_pause");
        cyc(0, 0, 1, 1, 3'd7, 0, 0, 0, "idle");

        // Full run; a pause rise during BLINK is ignored.
        cyc(1, 0, 1, 1, 3'd7, 1, 1, 0, "start");
        run_hold(0, 3'd7, 3, "run7");
        count_down(0, "run");
        blink(0, 0, 4, "blink");
        cyc(0, 1, 1, 1, 3'd0, 0, 1, 0, "blink_pause");
        blink(0, 5, 3, "blink");
        cyc(0, 0, 1, 1, 3'd7, 0, 0, 1, "done");
        cyc(0, 0, 1, 1, 3'd7, 0, 0, 0, "idle_after");

        // Start and pause rise together: runs, not paused.
        cyc(1, 1, 1, 1, 3'd7, 1, 1, 0, "start_pause");
        run_hold(0, 3'd7, 3, "sp_run7");
        run_hold(0, 3'd6, 4, "sp_run6");

        // Pause two cycles into digit 5, hold, resume.
        run_hold(0, 3'd5, 2, "pre_pause");
        cyc(0, 1, 1, 1, 3'd5, 1, 1, 0, "pause");
        for (int i = 0; i < 4; i++) cyc(0, 1, 1, 1, 3'd5, 1, 1, 0, "paused_held");
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, 1, 3'd5, 1, 1, 0, "paused");
        cyc(0, 1, 1, 1, 3'd5, 1, 1, 0, "resume");
        cyc(0, 0, 1, 1, 3'd5, 1, 1, 0, "resumed");
        run_hold(0, 3'd4, 4, "after_resume4");
        run_hold(0, 3'd3, 2, "run3");

        // Restart at digit 3.
        cyc(1, 0, 1, 1, 3'd7, 1, 1, 0, "restart_run");
        run_hold(0, 3'd7, 3, "restart_hold7");
        count_down(0, "run_r");
        blink(0, 0, 3, "blink_r");

        // Restart during BLINK, then hold start high for 40 cycles.
        cyc(1, 0, 1, 1, 3'd7, 1, 1, 0, "restart_blink");
        run_hold(1, 3'd7, 3, "held7");
        count_down(1, "held_run");
        blink(1, 0, 8, "held_blink");
        cyc(0, 0, 1, 1, 3'd7, 0, 0, 1, "done2");
        cyc(0, 0, 1, 1, 3'd7, 0, 0, 0, "idle2");

        // Reset in the middle of BLINK: no done pulse.
        cyc(1, 0, 1, 1, 3'd7, 1, 1, 0, "start3");
        run_hold(0, 3'd7, 3, "run7_3");
        count_down(0, "run_3");
        blink(0, 0, 3, "blink_3");
        cyc(0, 0, 0, 1, 3'd7, 0, 0, 0, "rst_blink");
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 1, 3'd7, 0, 0, 0, "post_rst");

        // Let the monitor drain, bounded.
        for (int i = 0; i < 10 && q_exp.size() != 0; i++) @(negedge clk);
        if (q_exp.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expectations, expected 0", q_exp.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
